regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, per-source queue depth in entries (DEPTH >= 1).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port alu_valid, input, 1, ALU writeback request valid.
REQ-005 The block SHALL have port alu_ready, output, 1, ALU queue can accept.
REQ-006 The block SHALL have port alu_rd, input, 5, ALU destination register.
REQ-007 The block SHALL have port alu_data, input, 32, ALU writeback data.
REQ-008 The block SHALL have ports lsu_valid, lsu_ready, lsu_rd and lsu_data, with the same directions, widths and meanings as the ALU ports, for the load unit.
REQ-009 The block SHALL have port RegWrite, output, 1, register-file write enable.
REQ-010 The block SHALL have port Rd, output, 5, register-file write address.
REQ-011 The block SHALL have port Write_data, output, 32, register-file write data.
REQ-012 The block SHALL have port pending, output, 32, scoreboard bitmap of registers with a queued or in-flight write.

Function
REQ-013 A transfer SHALL occur on a source at a rising edge where valid and ready are both high; no other condition transfers.
REQ-014 Each ready SHALL equal NOT full of that source's queue, independent of valid and of a same-cycle pop.
REQ-015 A transfer with rd = 0 SHALL be accepted and discarded: no enqueue, no write, no pending bit.
REQ-016 Each source queue SHALL be FIFO, with entries {rd, data} and wrap-around read/write pointers.
REQ-017 Each cycle, if any queue head is valid, the arbiter SHALL pop exactly one head and load {RegWrite=1, Rd, Write_data} into registered outputs at the next edge; otherwise RegWrite=0 and Rd/Write_data hold.
REQ-018 When only one head is valid, that head SHALL be granted.
REQ-019 When both heads are valid, the source not granted most recently SHALL be granted (round-robin); last-grant resets to LSU, so the ALU wins the first tie.
REQ-020 Latency SHALL be: transfer at edge k into empty queues gives RegWrite high from edge k+1 to k+2; the register file writes at edge k+2.
REQ-021 Sustained throughput SHALL be one write per cycle; with both sources saturated, grants alternate ALU/LSU.
REQ-022 Same-source writes SHALL retire in acceptance order; cross-source ordering is governed by arbitration only.
REQ-023 pending[r] SHALL be 1 iff any valid entry in either queue, or the output stage while RegWrite=1, targets r; pending[0] SHALL be constant 0; pending is combinational from state.
REQ-024 Issue logic SHALL stall on pending[rd] before issuing a second write to the same rd from the other source; the arbiter provides no cross-source hazard resolution.
REQ-025 A push to an empty queue SHALL NOT be granted in the same cycle (no bypass).

Reset
REQ-026 While reset_n is low, all queues SHALL be empty, RegWrite=0, Rd=0, Write_data=0, pending=0, alu_ready=lsu_ready=1, and last-grant=LSU.
REQ-027 Assertion of reset_n mid-operation SHALL discard all queued and in-flight writes immediately, with no partial write.
REQ-028 Operation SHALL resume at the first rising edge after reset_n deasserts.

Structure
REQ-029 XLEN=32, REG_ADDR_W=5, NUM_REGS=32 and the source-select enum {SRC_ALU, SRC_LSU} SHALL reside in the shared package riscv_pkg.
REQ-030 The per-source queue SHALL be a sub-module wb_fifo, parameterized by DEPTH and instantiated twice.

Verification
REQ-031 Single write: ALU push rd=5, data=0xDEADBEEF at edge 0 -> RegWrite=1, Rd=5, Write_data=0xDEADBEEF in cycle 1-2; pending[5]=1 from edge 0 until edge 2.
REQ-032 Tie: ALU (rd=1, 0x11) and LSU (rd=2, 0x22) pushed at the same edge after reset -> ALU written first, LSU next cycle; four pairs alternate A,L,A,L.
REQ-033 Full/backpressure: DEPTH=2, LSU pushes 3 with ALU saturating -> lsu_ready=0 after 2 queued, third accepted only after a pop, and all three retire in order.
REQ-034 x0: ALU push rd=0, data=0x12345678 -> no RegWrite, pending stays 0, alu_ready remains 1.
REQ-035 Reset mid-flight: 3 entries queued, reset_n low for 1 cycle -> RegWrite=0 and pending=0 at once, no stale write after release, and the next push behaves as in REQ-031.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V core constants, writeback source select and writeback entry type.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSU = 1'b1
    } src_e;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

    // One-hot decode of a register address into a scoreboard bitmap.
    function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
        logic [NUM_REGS-1:0] v;
        v     = '0;
        v[rd] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Per-source writeback queue: DEPTH-entry FIFO of {rd, data} with a pending-register bitmap.
// Latency: a push is visible at the head from the cycle after the push edge (no bypass).
// Backpressure: push_rdy_o is simply NOT full, regardless of a same-cycle pop.
module wb_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                push_vld_i,
    input  wb_entry_t           push_dat_i,
    output logic                push_rdy_o,
    input  logic                pop_i,
    output logic                head_vld_o,
    output wb_entry_t           head_dat_o,
    output logic [NUM_REGS-1:0] pend_o
);

    localparam int              PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    wb_entry_t        mem_q [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             push_en;
    logic             pop_en;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Per-entry valid bits make full/empty and the pending bitmap trivial.
    assign push_rdy_o = ~(&vld_q);
    assign head_vld_o = vld_q[rd_ptr_q];
    assign head_dat_o = mem_q[rd_ptr_q];
    assign push_en    = push_vld_i & push_rdy_o;
    assign pop_en     = pop_i & head_vld_o;

    // Next-state for valid bits and wrap-around pointers.
    always_comb begin
        vld_d    = vld_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (pop_en) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = next_ptr(rd_ptr_q);
        end
        if (push_en) begin
            vld_d[wr_ptr_q] = 1'b1;
            wr_ptr_d        = next_ptr(wr_ptr_q);
        end
    end

    // Control state; reset empties the queue immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            vld_q    <= vld_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage; contents are qualified by vld_q so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    // Bitmap of destination registers held by valid entries.
    always_comb begin
        pend_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i]) begin
                pend_o[mem_q[i].rd] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin merge of ALU and LSU writeback streams into one register-file write port.
// Latency: transfer at edge k into empty queues -> RegWrite high k+1..k+2; one write per cycle.
// Backpressure: each *_ready is NOT full of that source's queue; rd=0 transfers are dropped.
module regfile_wb_arbiter
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [REG_ADDR_W-1:0] lsu_rd,
    input  logic [XLEN-1:0]       lsu_data,
    output logic                  RegWrite,
    output logic [REG_ADDR_W-1:0] Rd,
    output logic [XLEN-1:0]       Write_data,
    output logic [NUM_REGS-1:0]   pending
);

    wb_entry_t             alu_head_dat, lsu_head_dat;
    logic                  alu_head_vld, lsu_head_vld;
    logic [NUM_REGS-1:0]   alu_pend, lsu_pend;
    logic                  gnt_alu, gnt_lsu;

    src_e                  last_q, last_d;
    logic                  reg_write_q, reg_write_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic [XLEN-1:0]       data_q, data_d;

    // Writes to x0 are accepted by the handshake but never enqueued.
    wb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push_vld_i (alu_valid & (alu_rd != '0)),
        .push_dat_i ('{rd: alu_rd, data: alu_data}),
        .push_rdy_o (alu_ready),
        .pop_i      (gnt_alu),
        .head_vld_o (alu_head_vld),
        .head_dat_o (alu_head_dat),
        .pend_o     (alu_pend)
    );

    wb_fifo #(.DEPTH(DEPTH)) u_lsu_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push_vld_i (lsu_valid & (lsu_rd != '0)),
        .push_dat_i ('{rd: lsu_rd, data: lsu_data}),
        .push_rdy_o (lsu_ready),
        .pop_i      (gnt_lsu),
        .head_vld_o (lsu_head_vld),
        .head_dat_o (lsu_head_dat),
        .pend_o     (lsu_pend)
    );

    // On a tie the source that lost last time wins; a lone valid head always wins.
    assign gnt_alu = alu_head_vld & (~lsu_head_vld | (last_q == SRC_LSU));
    assign gnt_lsu = lsu_head_vld & ~gnt_alu;

    // Select the granted head into the output stage; Rd/Write_data hold when idle.
    always_comb begin
        reg_write_d = 1'b0;
        rd_d        = rd_q;
        data_d      = data_q;
        last_d      = last_q;
        if (gnt_alu) begin
            reg_write_d = 1'b1;
            rd_d        = alu_head_dat.rd;
            data_d      = alu_head_dat.data;
            last_d      = SRC_ALU;
        end else if (gnt_lsu) begin
            reg_write_d = 1'b1;
            rd_d        = lsu_head_dat.rd;
            data_d      = lsu_head_dat.data;
            last_d      = SRC_LSU;
        end
    end

    // Output stage and round-robin history; reset kills any in-flight write at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reg_write_q <= 1'b0;
            rd_q        <= '0;
            data_q      <= '0;
            last_q      <= SRC_LSU;
        end else begin
            reg_write_q <= reg_write_d;
            rd_q        <= rd_d;
            data_q      <= data_d;
            last_q      <= last_d;
        end
    end

    assign RegWrite   = reg_write_q;
    assign Rd         = rd_q;
    assign Write_data = data_q;

    // Scoreboard: queued entries plus the write currently on the port; x0 never pending.
    always_comb begin
        pending = alu_pend | lsu_pend;
        if (reg_write_q) begin
            pending = pending | rd_onehot(rd_q);
        end
        pending[0] = 1'b0;
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed pushes, expected writes queued in arbitration order.
// Latency: n/a.
// Backpressure: drivers hold valid until ready, bounded by a cycle budget.
module tb_regfile_wb_arbiter;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid, lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        RegWrite;
    logic [4:0]  Rd;
    logic [31:0] Write_data;
    logic [31:0] pending;

    regfile_wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .lsu_valid  (lsu_valid),
        .lsu_ready  (lsu_ready),
        .lsu_rd     (lsu_rd),
        .lsu_data   (lsu_data),
        .RegWrite   (RegWrite),
        .Rd         (Rd),
        .Write_data (Write_data),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   wr_cnt = 0;
    int   base;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, required %b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: every register-file write must match the head of the expected queue.
    always @(negedge clk) begin
        if (RegWrite === 1'b1) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got rd=%0d data=0x%08h, required no write (t=%0t)",
                         Rd, Write_data, $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wb_rd", {27'b0, Rd}, {27'b0, mon_e.rd});
                chk("wb_data", Write_data, mon_e.data);
            end
        end
    end

    // Drivers are called just after a rising edge; they return just after the transfer edge.
    task automatic alu_push(input logic [4:0] rd, input logic [31:0] d);
        int n = 0;
        alu_valid = 1'b1;
        alu_rd    = rd;
        alu_data  = d;
        while (alu_ready !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) begin
            n_cmp++;
            n_bad++;
            $display("FAIL alu_push_timeout: alu_ready stayed %b, required 1", alu_ready);
        end
        @(posedge clk);
        #1;
        alu_valid = 1'b0;
    endtask

    task automatic lsu_push(input logic [4:0] rd, input logic [31:0] d);
        int n = 0;
        lsu_valid = 1'b1;
        lsu_rd    = rd;
        lsu_data  = d;
        while (lsu_ready !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) begin
            n_cmp++;
            n_bad++;
            $display("FAIL lsu_push_timeout: lsu_ready stayed %b, required 1", lsu_ready);
        end
        @(posedge clk);
        #1;
        lsu_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_left"}, exp_q.size(), 0);
        @(negedge clk);
        chkb({nm, "_idle_rw"}, RegWrite, 1'b0);
        chk({nm, "_idle_pend"}, pending, 32'h0);
    endtask

    // Single ALU write into an idle block, with pending and RegWrite traced per cycle.
    task automatic single_write(input string nm, input logic [4:0] rd, input logic [31:0] d);
        exp_q.push_back('{rd: rd, data: d});
        alu_push(rd, d);
        @(negedge clk);
        chkb({nm, "_pend_c0"}, pending[rd], 1'b1);
        chkb({nm, "_rw_c0"}, RegWrite, 1'b0);
        @(negedge clk);
        chkb({nm, "_pend_c1"}, pending[rd], 1'b1);
        chkb({nm, "_rw_c1"}, RegWrite, 1'b1);
        @(negedge clk);
        chk({nm, "_pend_c2"}, pending, 32'h0);
        chkb({nm, "_rw_c2"}, RegWrite, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        alu_valid = 1'b0;
        alu_rd    = '0;
        alu_data  = '0;
        lsu_valid = 1'b0;
        lsu_rd    = '0;
        lsu_data  = '0;

        // Reset state.
        @(negedge clk);
        chkb("rst_rw", RegWrite, 1'b0);
        chk("rst_rd", {27'b0, Rd}, 32'h0);
        chk("rst_data", Write_data, 32'h0);
        chk("rst_pend", pending, 32'h0);
        chkb("rst_alu_rdy", alu_ready, 1'b1);
        chkb("rst_lsu_rdy", lsu_ready, 1'b1);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Single write.
        single_write("sw", 5'd5, 32'hDEADBEEF);

        // Fresh reset so the round-robin history is back at LSU.
        reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Tie: four simultaneous pairs retire A,L,A,L,...
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{rd: 5'(2*i+1), data: 32'h11 * (2*i+1)});
            exp_q.push_back('{rd: 5'(2*i+2), data: 32'h11 * (2*i+2)});
        end
        fork
            begin
                for (int i = 0; i < 4; i++) alu_push(5'(2*i+1), 32'h11 * (2*i+1));
            end
            begin
                for (int j = 0; j < 4; j++) lsu_push(5'(2*j+2), 32'h11 * (2*j+2));
            end
        join
        drain("tie");

        // x0 is accepted and dropped.
        alu_push(5'd0, 32'h12345678);
        chkb("x0_alu_rdy", alu_ready, 1'b1);
        @(negedge clk);
        chk("x0_pend", pending, 32'h0);
        chkb("x0_rw_c1", RegWrite, 1'b0);
        @(negedge clk);
        chkb("x0_rw_c2", RegWrite, 1'b0);

        // Backpressure: LSU queue fills while the ALU keeps contending.
        exp_q.push_back('{rd: 5'd10, data: 32'hA000_000A});
        exp_q.push_back('{rd: 5'd20, data: 32'hB000_0014});
        exp_q.push_back('{rd: 5'd11, data: 32'hA000_000B});
        exp_q.push_back('{rd: 5'd21, data: 32'hB000_0015});
        exp_q.push_back('{rd: 5'd12, data: 32'hA000_000C});
        exp_q.push_back('{rd: 5'd22, data: 32'hB000_0016});
        exp_q.push_back('{rd: 5'd13, data: 32'hA000_000D});
        base = wr_cnt;
        fork
            begin
                alu_push(5'd10, 32'hA000_000A);
                alu_push(5'd11, 32'hA000_000B);
                alu_push(5'd12, 32'hA000_000C);
                alu_push(5'd13, 32'hA000_000D);
            end
            begin
                lsu_push(5'd20, 32'hB000_0014);
                lsu_push(5'd21, 32'hB000_0015);
                chkb("bp_lsu_full", lsu_ready, 1'b0);
                lsu_push(5'd22, 32'hB000_0016);
                chkb("bp_third_after_pop", (wr_cnt - base) >= 2, 1'b1);
            end
        join
        drain("bp");

        // Reset with three writes queued / in flight.
        alu_valid = 1'b1;
        alu_rd    = 5'd3;
        alu_data  = 32'h0300_0003;
        lsu_valid = 1'b1;
        lsu_rd    = 5'd4;
        lsu_data  = 32'h0400_0004;
        @(posedge clk);
        #1;
        lsu_valid = 1'b0;
        alu_rd    = 5'd6;
        alu_data  = 32'h0600_0006;
        @(posedge clk);
        #1;
        alu_valid = 1'b0;
        chkb("mf_rw_before", RegWrite, 1'b1);
        chk("mf_pend_before", pending, 32'h0000_0058);
        reset_n = 1'b0;
        #1;
        chkb("mf_rw_rst", RegWrite, 1'b0);
        chk("mf_pend_rst", pending, 32'h0);
        chkb("mf_alu_rdy_rst", alu_ready, 1'b1);
        chkb("mf_lsu_rdy_rst", lsu_ready, 1'b1);
        @(posedge clk);
        #1 reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chkb("mf_no_stale", RegWrite, 1'b0);
        end
        @(posedge clk);
        #1;
        single_write("sw2", 5'd5, 32'hDEADBEEF);

        chk("end_exp_left", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
